// File: rtl/exe_muldiv.sv
// Iterative radix-2 RV32M multiply/divide unit for the execute stage.
// Ports: clk/rst/flush, in_* request (valid/ready), out_* tagged result.
module exe_muldiv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;

    // Request decode: operand signedness, magnitudes, special divides
    logic              a_sgn, b_sgn, sa, sb;
    logic              div0, ovf, special;
    logic [XLEN-1:0]   abs_a, abs_b, spec_res;

    always_comb begin
        a_sgn    = in_op[2] ? ~in_op[0] : (in_op[1] ^ in_op[0]);
        b_sgn    = in_op[2] ? ~in_op[0] : (in_op == 3'd1);
        sa       = a_sgn & in_rs1[XLEN-1];
        sb       = b_sgn & in_rs2[XLEN-1];
        abs_a    = sa ? -in_rs1 : in_rs1;
        abs_b    = sb ? -in_rs2 : in_rs2;
        div0     = (in_rs2 == '0);
        ovf      = ~in_op[0] & (in_rs1 == MIN_NEG) & (&in_rs2);
        special  = in_op[2] & (div0 | ovf);
        if (div0) begin
            spec_res = in_op[1] ? in_rs1 : '1;
        end else begin
            spec_res = in_op[1] ? '0 : in_rs1;
        end
    end

    // One iteration: hi holds partial product / remainder,
    // lo holds the shifting multiplier / dividend-quotient
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     shifted;
    logic              ge;
    logic [XLEN-1:0]   hi_sub, hi_nx, lo_nx;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, fin_res;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        ge      = (shifted >= {1'b0, b_q});
        // Restored value is below b_q, so the low bits suffice
        hi_sub  = shifted[XLEN-1:0] - b_q;
        if (op_q[2]) begin
            hi_nx = ge ? hi_sub : shifted[XLEN-1:0];
            lo_nx = {lo_q[XLEN-2:0], ge};
        end else begin
            {hi_nx, lo_nx} = {mul_sum, lo_q[XLEN-1:1]};
        end
        prod     = {hi_nx, lo_nx};
        prod_fix = qneg_q ? -prod : prod;
        q_fix    = qneg_q ? -lo_nx : lo_nx;
        r_fix    = rneg_q ? -hi_nx : hi_nx;
        unique case (op_q)
            3'd0:             fin_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fin_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fin_res = q_fix;
            default:          fin_res = r_fix;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        qneg_d       = qneg_q;
        rneg_d       = rneg_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        b_d          = b_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d      = in_op;
                        out_tag_d = in_tag;
                        qneg_d    = sa ^ sb;
                        rneg_d    = sa;
                        cnt_d     = '0;
                        hi_d      = '0;
                        lo_d      = abs_a;
                        b_d       = abs_b;
                        if (special) begin
                            out_result_d = spec_res;
                            out_valid_d  = 1'b1;
                            state_d      = DONE;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    hi_d  = hi_nx;
                    lo_d  = lo_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) begin
                        out_result_d = fin_res;
                        out_valid_d  = 1'b1;
                        state_d      = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            b_q          <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            qneg_q       <= qneg_d;
            rneg_q       <= rneg_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            b_q          <= b_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;

endmodule
